// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command stage in front of the 4-bit combinational ALU. It takes one
// operation at a time, drives registered operands onto the ALU, then captures
// the opcode-selected result into an output register. The result is presented
// downstream as a back-pressurable stream with error and zero flags.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. A valid, once raised, stays high and its
// payload stays stable until that transfer edge. cmd_ready and res_valid are
// decoded from the state register only, so neither depends combinationally on
// cmd_valid or res_ready.
module alu_cmd_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   // command stream
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   // ALU operand drive
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   // ALU results
   input  logic [7:0]       alu_sum,
   input  logic [7:0]       alu_diff,
   input  logic [7:0]       alu_prod,
   input  logic [7:0]       alu_quot,
   input  logic [3:0]       alu_and,
   input  logic [3:0]       alu_or,
   input  logic [3:0]       alu_xor,
   input  logic [3:0]       alu_nota,
   input  logic [3:0]       alu_notb,
   // result stream
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data,
   output logic [3:0]       res_op,
   output logic             res_err,
   output logic             res_zero,
   output logic [CNT_W-1:0] done_cnt,
   // FSM state for observation
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_NOTA = 4'd7;
   localparam logic [3:0] OP_NOTB = 4'd8;

   state_t     state;
   logic [3:0] op_q;
   logic [7:0] sel_data;
   logic       sel_err;

   // Pick the ALU output for the latched opcode; the ALU's own divide-by-zero
   // flag is not used, the check is made on the registered B operand.
   always_comb begin
      sel_data = 8'h00;
      sel_err  = 1'b0;
      case (op_q)
         OP_ADD:  sel_data = alu_sum;
         OP_SUB:  sel_data = alu_diff;
         OP_MUL:  sel_data = alu_prod;
         OP_DIV: begin
            if (alu_b == 4'd0) begin
               sel_data = 8'hFF;
               sel_err  = 1'b1;
            end else begin
               sel_data = alu_quot;
            end
         end
         OP_AND:  sel_data = {4'h0, alu_and};
         OP_OR:   sel_data = {4'h0, alu_or};
         OP_XOR:  sel_data = {4'h0, alu_xor};
         OP_NOTA: sel_data = {4'h0, alu_nota};
         OP_NOTB: sel_data = {4'h0, alu_notb};
         default: begin
            sel_data = 8'h00;
            sel_err  = 1'b1;
         end
      endcase
   end

   // Sequencer FSM: accept in IDLE, let the ALU settle for one EXEC cycle,
   // hold the captured result in DONE until downstream takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         op_q     <= 4'd0;
         alu_a    <= 4'd0;
         alu_b    <= 4'd0;
         res_data <= 8'h00;
         res_op   <= 4'd0;
         res_err  <= 1'b0;
         res_zero <= 1'b0;
         done_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  alu_a <= cmd_a;
                  alu_b <= cmd_b;
                  op_q  <= cmd_op;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               res_data <= sel_data;
               res_op   <= op_q;
               res_err  <= sel_err;
               res_zero <= (sel_data == 8'h00);
               state    <= S_DONE;
            end
            S_DONE: begin
               if (res_ready) begin
                  done_cnt <= done_cnt + CNT_W'(1);
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign res_valid = (state == S_DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed vector table, hand-written
// backpressure / reset / counter-wrap sequences, and random operations
// checked against a behavioural reference model through an expected queue.
module tb_alu_cmd_sequencer;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [3:0]       cmd_op = 4'd0;
   logic [3:0]       cmd_a = 4'd0;
   logic [3:0]       cmd_b = 4'd0;
   logic [3:0]       alu_a, alu_b;
   logic [7:0]       alu_sum, alu_diff, alu_prod, alu_quot;
   logic [3:0]       alu_and, alu_or, alu_xor, alu_nota, alu_notb;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [7:0]       res_data;
   logic [3:0]       res_op;
   logic             res_err, res_zero;
   logic [CNT_W-1:0] done_cnt;
   logic [1:0]       dbg_state;

   int total = 0;
   int bad = 0;
   int exp_cnt = 0;
   logic [13:0] exp_q[$];   // {op, err, zero, data}

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- ALU environment model ----------------
   // Divide-by-zero quotient is deliberately garbage so sampling it shows up.
   always_comb begin
      alu_sum  = {4'h0, alu_a} + {4'h0, alu_b};
      alu_diff = {4'h0, alu_a} - {4'h0, alu_b};
      alu_prod = {4'h0, alu_a} * {4'h0, alu_b};
      alu_quot = (alu_b == 4'd0) ? 8'hA5 : ({4'h0, alu_a} / {4'h0, alu_b});
      alu_and  = alu_a & alu_b;
      alu_or   = alu_a | alu_b;
      alu_xor  = alu_a ^ alu_b;
      alu_nota = ~alu_a;
      alu_notb = ~alu_b;
   end

   alu_cmd_sequencer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b),
      .alu_sum(alu_sum), .alu_diff(alu_diff), .alu_prod(alu_prod), .alu_quot(alu_quot),
      .alu_and(alu_and), .alu_or(alu_or), .alu_xor(alu_xor),
      .alu_nota(alu_nota), .alu_notb(alu_notb),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_op(res_op), .res_err(res_err), .res_zero(res_zero),
      .done_cnt(done_cnt), .dbg_state(dbg_state)
   );

   // ---------------- reference model ----------------
   function automatic logic [13:0] ref_model(int op, int a, int b);
      int r;
      bit e;
      r = 0;
      e = 0;
      case (op)
         0: r = (a + b) % 256;
         1: r = (a - b + 256) % 256;
         2: r = a * b;
         3: if (b == 0) begin r = 255; e = 1; end else r = a / b;
         4: r = a & b;
         5: r = a | b;
         6: r = a ^ b;
         7: r = 15 - a;
         8: r = 15 - b;
         default: begin r = 0; e = 1; end
      endcase
      return {4'(op), e, (r == 0), 8'(r)};
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, " res_valid"}, 32'(res_valid), 32'd0);
      check({tag, " alu_a"},     32'(alu_a),     32'd0);
      check({tag, " alu_b"},     32'(alu_b),     32'd0);
      check({tag, " res_data"},  32'(res_data),  32'd0);
      check({tag, " res_op"},    32'(res_op),    32'd0);
      check({tag, " res_err"},   32'(res_err),   32'd0);
      check({tag, " res_zero"},  32'(res_zero),  32'd0);
      check({tag, " done_cnt"},  32'(done_cnt),  32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
   endtask

   // ---------------- driver ----------------
   // Issue one command, check its timing, hold res_ready low for 'hold'
   // cycles, then take the result. Returns the captured result fields.
   task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input int hold, output logic [13:0] got);
      bit seen;
      logic [13:0] first;
      got = '0;
      @(negedge clk);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready) begin seen = 1; break; end
         @(negedge clk);
      end
      if (!seen) begin
         check("accept timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op = 4'(~op); cmd_a = 4'(~a); cmd_b = 4'(~b);   // fields must not matter now
      @(negedge clk);
      check("exec cmd_ready", 32'(cmd_ready), 32'd0);
      check("exec res_valid", 32'(res_valid), 32'd0);
      check("exec alu_a", 32'(alu_a), 32'(a));
      check("exec alu_b", 32'(alu_b), 32'(b));
      @(negedge clk);
      check("done res_valid", 32'(res_valid), 32'd1);
      first = {res_op, res_err, res_zero, res_data};
      got = first;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold res_valid", 32'(res_valid), 32'd1);
         check("hold stable", 32'({res_op, res_err, res_zero, res_data}), 32'(first));
         check("hold cmd_ready", 32'(cmd_ready), 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      check("handoff done_cnt", 32'(done_cnt), 32'(exp_cnt));
      @(negedge clk);
      check("after res_valid", 32'(res_valid), 32'd0);
      check("after cmd_ready", 32'(cmd_ready), 32'd1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] data;
      logic       err;
      logic       zero;
   } vec_t;

   vec_t vecs[10];
   int   wrap_exp[5];

   initial begin
      logic [13:0] got;
      logic [13:0] exp;

      vecs[0] = '{4'd1, 4'd0,  4'd15, 8'hF1, 1'b0, 1'b0};  // SUB wraps
      vecs[1] = '{4'd2, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0};  // MUL max
      vecs[2] = '{4'd3, 4'd13, 4'd4,  8'h03, 1'b0, 1'b0};  // DIV
      vecs[3] = '{4'd3, 4'd9,  4'd0,  8'hFF, 1'b1, 1'b0};  // DIV by zero
      vecs[4] = '{4'd12, 4'd5, 4'd6,  8'h00, 1'b1, 1'b1};  // illegal
      vecs[5] = '{4'd0, 4'd15, 4'd15, 8'h1E, 1'b0, 1'b0};  // ADD carry
      vecs[6] = '{4'd5, 4'd12, 4'd3,  8'h0F, 1'b0, 1'b0};  // OR
      vecs[7] = '{4'd6, 4'd9,  4'd9,  8'h00, 1'b0, 1'b1};  // XOR to zero
      vecs[8] = '{4'd8, 4'd0,  4'd5,  8'h0A, 1'b0, 1'b0};  // NOTB
      vecs[9] = '{4'd15, 4'd0, 4'd0,  8'h00, 1'b1, 1'b1};  // illegal top code
      wrap_exp = '{1, 2, 3, 0, 1};

      // reset state
      #2;
      check_reset_values("reset");
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_values("post-reset");

      // reset mid-EXEC: discard the command, counter stays 0
      @(negedge clk);
      cmd_op = 4'd2; cmd_a = 4'd7; cmd_b = 4'd3; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("mid-exec reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("no res_valid after reset", 32'(res_valid), 32'd0);
      check("done_cnt after reset", 32'(done_cnt), 32'd0);
      exp_cnt = 0;

      // directed vector table
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, got);
         check($sformatf("vec%0d data", i), 32'(got[7:0]), 32'(vecs[i].data));
         check($sformatf("vec%0d err", i),  32'(got[9]),   32'(vecs[i].err));
         check($sformatf("vec%0d zero", i), 32'(got[8]),   32'(vecs[i].zero));
         check($sformatf("vec%0d op", i),   32'(got[13:10]), 32'(vecs[i].op));
      end

      // backpressure: AND result held while a new command waits
      @(negedge clk);
      cmd_op = 4'd4; cmd_a = 4'b1100; cmd_b = 4'b1010; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_op = 4'd0; cmd_a = 4'd3; cmd_b = 4'd5;    // next command, valid stays high
      @(negedge clk);
      @(negedge clk);
      check("bp res_valid", 32'(res_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp res_data", 32'(res_data), 32'h08);
         check("bp cmd_ready", 32'(cmd_ready), 32'd0);
         check("bp alu_a held", 32'(alu_a), 32'b1100);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      check("bp done_cnt", 32'(done_cnt), 32'(exp_cnt));
      @(negedge clk);
      check("bp cmd_ready back", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("bp next accepted a", 32'(alu_a), 32'd3);
      check("bp next accepted b", 32'(alu_b), 32'd5);
      @(negedge clk);
      @(negedge clk);
      check("bp next res_data", 32'(res_data), 32'h08);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);

      // counter wrap with CNT_W=2
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         run_op(4'd7, 4'd0, 4'd9, 0, got);
         check("wrap data", 32'(got[7:0]), 32'h0F);
         check($sformatf("wrap cnt%0d", i), 32'(done_cnt), 32'(wrap_exp[i]));
      end

      // random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [3:0] op, a, b;
         op = 4'($urandom_range(0, 15));
         a  = 4'($urandom_range(0, 15));
         b  = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15));
         exp_q.push_back(ref_model(int'(op), int'(a), int'(b)));
         run_op(op, a, b, $urandom_range(0, 3), got);
         exp = exp_q.pop_front();
         check($sformatf("rand%0d op%0d a%0d b%0d", i, op, a, b), 32'(got), 32'(exp));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
